kfps2kb_keycode_fifo: RTL and testbench

//  Downstream consumer of the PS/2 keyboard controller's irq/keycode/clear_keycode interface.

---
 rtl/kfps2kb_keycode_fifo.sv | 131 +++++++++++++
 tb/tb_kfps2kb_keycode_fifo.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kfps2kb_keycode_fifo.sv
// Takes keycodes from the PS/2 keyboard controller, acknowledges each one and queues it in a
// first-word-fall-through FIFO that the host drains with a valid/ready handshake.
module kfps2kb_keycode_fifo #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 4,
  parameter logic        DROP_ERROR_CODE = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     kb_irq,
  input  logic [7:0]               kb_keycode,
  output logic                     kb_clear_keycode,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int unsigned PW    = FIFO_DEPTH_LOG2;
  localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            clear_d;
  logic            capture;

  logic [7:0]      mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_d;
  logic [7:0]      out_data_d;
  logic            is_err;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // Capture FSM: one keycode per kb_irq assertion, WAIT blocks re-capture of a stale code
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kb_irq) begin
          capture = 1'b1;
          clear_d = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_WAIT;
      S_WAIT:  if (!kb_irq) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      kb_clear_keycode <= 1'b0;
    end else begin
      state_q          <= state_d;
      kb_clear_keycode <= clear_d;
    end
  end

  // Push/pop decisions; a full FIFO still accepts a push when the host pops in the same cycle
  always_comb begin
    is_err = DROP_ERROR_CODE && (kb_keycode == 8'hFF);
    full   = (count == CW'(DEPTH));
    pop    = out_valid && out_ready;
    push   = capture && !is_err && (!full || pop);
    drop   = capture && !is_err && full && !pop;
  end

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Next head word: the pushed byte when it becomes the head, else the entry behind the popped one
  always_comb begin
    out_data_d = out_data;
    if (push && ((count == CW'(0)) || (pop && (count == CW'(1))))) begin
      out_data_d = kb_keycode;
    end else if (pop && (count > CW'(1))) begin
      out_data_d = mem[rd_ptr + PW'(1)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      mem[wr_ptr] <= kb_keycode;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count_d;
      out_valid <= (count_d != CW'(0));
      out_data  <= out_data_d;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kfps2kb_keycode_fifo.sv
// Scoreboard bench for kfps2kb_keycode_fifo: expected keycodes are queued when sent and
// compared in order as the host side pops them.
module tb_kfps2kb_keycode_fifo;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       kb_irq = 1'b0;
  logic [7:0] kb_keycode = 8'h00;
  logic       out_ready = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       ready1 = 1'b1;

  logic       kb_clear_keycode, out_valid, overflow;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       clear1, valid1, overflow1;
  logic [7:0] data1;
  logic [4:0] count1;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  always #5 clock = ~clock;

  kfps2kb_keycode_fifo #(.FIFO_DEPTH_LOG2(4), .DROP_ERROR_CODE(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .kb_irq(kb_irq), .kb_keycode(kb_keycode),
    .kb_clear_keycode(kb_clear_keycode), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  kfps2kb_keycode_fifo #(.FIFO_DEPTH_LOG2(4), .DROP_ERROR_CODE(1'b1)) dut_drop (
    .clock(clock), .reset_n(reset_n), .kb_irq(kb_irq), .kb_keycode(kb_keycode),
    .kb_clear_keycode(clear1), .out_valid(valid1), .out_data(data1),
    .out_ready(ready1), .count(count1), .overflow(overflow1), .clear_overflow(1'b0)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sends one keycode with a single-cycle irq and returns to IDLE (3 cycles)
  task automatic send_key(input logic [7:0] k);
    kb_irq = 1'b1;
    kb_keycode = k;
    step();
    kb_irq = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    total++;
    if ({kb_clear_keycode, out_valid, overflow} !== 3'b000 || count !== 5'd0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset: clr=%b valid=%b ovf=%b count=%0d data=%h required 0 0 0 0 00",
               kb_clear_keycode, out_valid, overflow, count, out_data);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b0;
    kb_irq = 1'b1;
    kb_keycode = 8'h1C;
    exp_q.push_back(8'h1C);
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h1C || count !== 5'd1 || kb_clear_keycode !== 1'b1) begin
      bad++;
      $display("FAIL single_capture: valid=%b data=%h count=%0d clr=%b required 1 1c 1 1",
               out_valid, out_data, count, kb_clear_keycode);
    end
    kb_irq = 1'b0;
    step();
    total++;
    if (kb_clear_keycode !== 1'b0) begin
      bad++;
      $display("FAIL single_ack_width: clr=%b required 0", kb_clear_keycode);
    end
    step();
    out_ready = 1'b1;
    exp = exp_q.pop_front();
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("FAIL single_pop: data=%h required %h", out_data, exp);
    end
    step();
    out_ready = 1'b0;
    total++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: count=%0d valid=%b required 0 0", count, out_valid);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] keys [3];
    keys[0] = 8'h1C; keys[1] = 8'h9C; keys[2] = 8'h32;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      kb_irq = 1'b1;
      kb_keycode = keys[i];
      exp_q.push_back(keys[i]);
      step();
      kb_irq = 1'b0;
      exp = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        bad++;
        $display("FAIL seq_pop%0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
      end
      step();
      step();
    end
    out_ready = 1'b0;
    total++;
    if (count !== 5'd0) begin
      bad++;
      $display("FAIL seq_count: count=%0d required 0", count);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
      send_key(8'(8'h10 + i));
    end
    total++;
    if (count !== 5'd16 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: count=%0d ovf=%b required 16 1", count, overflow);
    end
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    total++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      bad++;
      $display("FAIL overflow_clear: ovf=%b count=%0d required 0 16", overflow, count);
    end
  endtask

  task automatic test_full_push_pop();
    kb_irq = 1'b1;
    kb_keycode = 8'h45;
    out_ready = 1'b1;
    exp = exp_q.pop_front();
    exp_q.push_back(8'h45);
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("FAIL full_head: data=%h required %h", out_data, exp);
    end
    step();
    kb_irq = 1'b0;
    out_ready = 1'b0;
    total++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_push_pop: count=%0d ovf=%b required 16 0", count, overflow);
    end
    step();
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        bad++;
        $display("FAIL full_drain%0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
      end
      step();
    end
    step();
    total++;
    if (out_valid !== 1'b0 || count !== 5'd0 || out_data !== 8'h45) begin
      bad++;
      $display("FAIL empty_hold: valid=%b count=%0d data=%h required 0 0 45", out_valid, count, out_data);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_error_code();
    out_ready = 1'b0;
    kb_irq = 1'b1;
    kb_keycode = 8'hFF;
    exp_q.push_back(8'hFF);
    step();
    kb_irq = 1'b0;
    total++;
    if (count !== 5'd1 || out_data !== 8'hFF) begin
      bad++;
      $display("FAIL err_kept: count=%0d data=%h required 1 ff", count, out_data);
    end
    total++;
    if (count1 !== 5'd0 || clear1 !== 1'b1) begin
      bad++;
      $display("FAIL err_dropped: count=%0d clr=%b required 0 1", count1, clear1);
    end
    step();
    step();
    kb_irq = 1'b1;
    kb_keycode = 8'h2A;
    exp_q.push_back(8'h2A);
    step();
    kb_irq = 1'b0;
    total++;
    if (count1 !== 5'd1 || data1 !== 8'h2A) begin
      bad++;
      $display("FAIL err_other_kept: count=%0d data=%h required 1 2a", count1, data1);
    end
    step();
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        bad++;
        $display("FAIL err_drain%0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_irq_hold_and_reset();
    int acks = 0;
    out_ready = 1'b0;
    kb_irq = 1'b1;
    kb_keycode = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      step();
      if (kb_clear_keycode === 1'b1) acks++;
      kb_keycode = 8'(8'h60 + i);
    end
    kb_irq = 1'b0;
    total++;
    if (count !== 5'd1 || out_data !== 8'h5A || acks != 1) begin
      bad++;
      $display("FAIL irq_hold: count=%0d data=%h acks=%0d required 1 5a 1", count, out_data, acks);
    end
    step();
    send_key(8'h11);
    send_key(8'h22);
    kb_irq = 1'b1;
    kb_keycode = 8'h33;
    step();
    total++;
    if (count !== 5'd4 || kb_clear_keycode !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: count=%0d clr=%b required 4 1", count, kb_clear_keycode);
    end
    reset_n = 1'b0;
    kb_irq = 1'b0;
    step();
    total++;
    if ({kb_clear_keycode, out_valid, overflow} !== 3'b000 || count !== 5'd0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset: clr=%b valid=%b ovf=%b count=%0d data=%h required 0 0 0 0 00",
               kb_clear_keycode, out_valid, overflow, count, out_data);
    end
    reset_n = 1'b1;
    exp_q.delete();
    step();
    step();
    total++;
    if (count !== 5'd0 || kb_clear_keycode !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: count=%0d clr=%b required 0 0", count, kb_clear_keycode);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_overflow();
    test_full_push_pop();
    test_error_code();
    test_irq_hold_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
